// File: rtl/simd_pkg.sv
// Shared constants, beat flag bundle and the signed saturation helper for the SIMD MAC path.
package simd_pkg;

    localparam int SIMD_DATA_WIDTH = 64;
    localparam int LANE_W          = 16;
    localparam int LANES           = SIMD_DATA_WIDTH / LANE_W;
    localparam int MUL_W           = LANE_W + 1;
    localparam int PROD_W          = 2 * MUL_W;
    localparam int SUM_W           = PROD_W + 2;
    localparam int WIDE_W          = 65;

    typedef struct packed {
        logic clr;
        logic last;
        logic sgn;
    } mac_flags_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [WIDE_W-1:0] sat_clamp(
        input logic signed [WIDE_W-1:0] value,
        input int                       width
    );
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        max_v = (65'sd1 <<< (width - 32'sd1)) - 65'sd1;
        min_v = ~max_v;
        if (value > max_v) begin
            sat_clamp = max_v;
        end else if (value < min_v) begin
            sat_clamp = min_v;
        end else begin
            sat_clamp = value;
        end
    endfunction

endpackage

// File: rtl/simd_mul_lane.sv
// One lane multiplier: 17x17 signed operands (already sign/zero extended) to a full-width product.
module simd_mul_lane
    import simd_pkg::*;
(
    input  logic signed [MUL_W-1:0]  a_i,
    input  logic signed [MUL_W-1:0]  b_i,
    output logic signed [PROD_W-1:0] p_o
);

    // Full product width so 0xFFFF x 0xFFFF unsigned lanes never wrap.
    assign p_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/simd_mac_accum.sv
// Two-stage SIMD MAC: S1 registers lane products, S2 sums, accumulates with saturation
// and holds one result per chain for the writeback handshake.
module simd_mac_accum
    import simd_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIMD_DATA_WIDTH-1:0] shuf_data,
    input  logic [SIMD_DATA_WIDTH-1:0] coeff,
    input  logic                       in_signed,
    input  logic                       in_clr,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIMD_DATA_WIDTH-1:0] out_data,
    output logic                       out_sat
);

    localparam int ACC1_W = ACC_W + 1;

    logic signed [PROD_W-1:0]   mul_p_s   [LANES];
    logic signed [PROD_W-1:0]   s1_prod_q [LANES];
    logic signed [PROD_W-1:0]   s1_prod_d [LANES];
    mac_flags_t                 s1_flags_q, s1_flags_d;
    logic                       s1_valid_q, s1_valid_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       sticky_q, sticky_d;
    logic                       out_valid_q, out_valid_d;
    logic [SIMD_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_sat_q, out_sat_d;

    logic                       s1_adv_s;
    logic                       accept_s;
    logic signed [SUM_W-1:0]    lane_sum_s;
    logic signed [ACC1_W-1:0]   base_s;
    logic signed [ACC1_W-1:0]   nxt_s;
    logic signed [WIDE_W-1:0]   nxt_wide_s;
    logic signed [WIDE_W-1:0]   clamp_s;
    logic signed [ACC_W-1:0]    acc_nxt_s;
    logic                       sat_s;
    logic                       sticky_nxt_s;
    logic                       unused_s;

    // Only a last beat facing a still-unconsumed result blocks the pipe.
    assign s1_adv_s = s1_valid_q & ~(s1_flags_q.last & out_valid_q & ~out_ready);
    assign in_ready = ~s1_valid_q | s1_adv_s;
    assign accept_s = in_valid & in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [MUL_W-1:0] a_s;
        logic signed [MUL_W-1:0] b_s;
        assign a_s = {in_signed & shuf_data[g*LANE_W + LANE_W - 1], shuf_data[g*LANE_W +: LANE_W]};
        assign b_s = {in_signed & coeff[g*LANE_W + LANE_W - 1], coeff[g*LANE_W +: LANE_W]};
        simd_mul_lane u_mul (
            .a_i (a_s),
            .b_i (b_s),
            .p_o (mul_p_s[g])
        );
    end

    // Adder tree, chain base selection and saturating accumulate for the beat in S1.
    always_comb begin
        lane_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_s = lane_sum_s + SUM_W'(s1_prod_q[i]);
        end
        base_s       = s1_flags_q.clr ? '0 : ACC1_W'(acc_q);
        nxt_s        = base_s + ACC1_W'(lane_sum_s);
        nxt_wide_s   = WIDE_W'(nxt_s);
        clamp_s      = sat_clamp(nxt_wide_s, ACC_W);
        sat_s        = (clamp_s != nxt_wide_s);
        acc_nxt_s    = clamp_s[ACC_W-1:0];
        sticky_nxt_s = (s1_flags_q.clr ? 1'b0 : sticky_q) | sat_s;
    end

    assign unused_s = ^{s1_flags_q.sgn, clamp_s[WIDE_W-1:ACC_W]};

    // S1 next state: a new beat overwrites S1 even when the old one advances that edge.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_flags_d = s1_flags_q;
        if (accept_s) begin
            s1_valid_d     = 1'b1;
            s1_prod_d      = mul_p_s;
            s1_flags_d.clr  = in_clr;
            s1_flags_d.last = in_last;
            s1_flags_d.sgn  = in_signed;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: accumulator always follows S1; output loads on last, clears on handshake.
    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (s1_adv_s) begin
            acc_d    = acc_nxt_s;
            sticky_d = sticky_nxt_s;
        end else begin
            acc_d    = acc_q;
            sticky_d = sticky_q;
        end
        if (s1_adv_s && s1_flags_q.last) begin
            out_valid_d = 1'b1;
            out_data_d  = SIMD_DATA_WIDTH'(acc_nxt_s);
            out_sat_d   = sticky_nxt_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_flags_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= '0;
            end
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_flags_q  <= s1_flags_d;
            s1_prod_q   <= s1_prod_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
